// File: rtl/alu_exec_stage.sv
// Execute/writeback stage: reads two operands from an external register file, runs a single-cycle
// ALU op or a shift-add multiply, and writes the result back with zero/carry flags.
module alu_exec_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2:0]        in_op_i,
  input  logic [ADDR_W-1:0] in_rd_i,
  input  logic [ADDR_W-1:0] in_rs1_i,
  input  logic [ADDR_W-1:0] in_rs2_i,
  output logic [ADDR_W-1:0] raddr1_o,
  output logic [ADDR_W-1:0] raddr2_o,
  input  logic [DATA_W-1:0] rdata1_i,
  input  logic [DATA_W-1:0] rdata2_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              done_o,
  output logic              flag_z_o,
  output logic              flag_c_o
);

  localparam int unsigned ShW  = $clog2(DATA_W);
  localparam int unsigned CntW = ShW;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpShl = 3'b101;
  localparam logic [2:0] OpShr = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  typedef enum logic [2:0] {StIdle, StRead, StExec, StMul, StWb} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] raddr1_q, raddr1_d;
  logic [ADDR_W-1:0] raddr2_q, raddr2_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_c_q, flag_c_d;
  logic              wb_act;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      op_q     <= '0;
      rd_q     <= '0;
      raddr1_q <= '0;
      raddr2_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      raddr1_q <= raddr1_d;
      raddr2_q <= raddr2_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    raddr1_d = raddr1_q;
    raddr2_d = raddr2_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    case (state_q)
      StIdle: begin
        // Read addresses are loaded on accept so they present during READ and hold afterwards.
        if (in_valid_i) begin
          op_d     = in_op_i;
          rd_d     = in_rd_i;
          raddr1_d = in_rs1_i;
          raddr2_d = in_rs2_i;
          state_d  = StRead;
        end
      end
      StRead: begin
        a_d     = rdata1_i;
        b_d     = rdata2_i;
        res_d   = '0;
        carry_d = 1'b0;
        cnt_d   = '0;
        state_d = (op_q == OpMul) ? StMul : StExec;
      end
      StExec: begin
        carry_d = 1'b0;
        case (op_q)
          OpAdd:   {carry_d, res_d} = {1'b0, a_q} + {1'b0, b_q};
          OpSub: begin
            res_d   = a_q - b_q;
            carry_d = (a_q < b_q);
          end
          OpAnd:   res_d = a_q & b_q;
          OpOr:    res_d = a_q | b_q;
          OpXor:   res_d = a_q ^ b_q;
          OpShl:   res_d = a_q << b_q[ShW-1:0];
          OpShr:   res_d = a_q >> b_q[ShW-1:0];
          default: res_d = '0;
        endcase
        state_d = StWb;
      end
      StMul: begin
        // One multiplier bit per cycle; a_q walks left, b_q walks right.
        if (b_q[0]) res_d = res_q + a_q;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(DATA_W - 1)) state_d = StWb;
      end
      StWb: begin
        flag_z_d = (res_q == '0);
        flag_c_d = carry_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Reset in the WB cycle must keep the external register file from committing.
  assign wb_act     = (state_q == StWb) && !rst_i;
  assign in_ready_o = (state_q == StIdle);
  assign we_o       = wb_act;
  assign done_o     = wb_act;
  assign waddr_o    = wb_act ? rd_q : '0;
  assign wdata_o    = wb_act ? res_q : '0;
  assign raddr1_o   = raddr1_q;
  assign raddr2_o   = raddr2_q;
  assign flag_z_o   = flag_z_q;
  assign flag_c_o   = flag_c_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a behavioural register file and an expected-write queue.
module tb_alu_exec_stage;

  typedef struct {
    logic [3:0]  rd;
    logic [15:0] data;
    logic        z;
    logic        c;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [3:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [3:0]  raddr1, raddr2, waddr;
  logic [15:0] rdata1, rdata2, wdata;
  logic        we, done, flag_z, flag_c;

  logic [15:0] rf [16];
  logic        pl_we = 1'b0;
  logic [3:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;
  int          we_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        sb[$];

  alu_exec_stage #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_op_i    (in_op),
    .in_rd_i    (in_rd),
    .in_rs1_i   (in_rs1),
    .in_rs2_i   (in_rs2),
    .raddr1_o   (raddr1),
    .raddr2_o   (raddr2),
    .rdata1_i   (rdata1),
    .rdata2_i   (rdata2),
    .we_o       (we),
    .waddr_o    (waddr),
    .wdata_o    (wdata),
    .done_o     (done),
    .flag_z_o   (flag_z),
    .flag_c_o   (flag_c)
  );

  always #5 clk = ~clk;

  assign rdata1 = rf[raddr1];
  assign rdata2 = rf[raddr2];

  always @(posedge clk) begin
    if (we) begin
      rf[waddr] <= wdata;
      we_cnt    <= we_cnt + 1;
    end else if (pl_we) begin
      rf[pl_addr] <= pl_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [31:0] p;
    logic [3:0]  sh;
    sh = b[3:0];
    p  = 32'(a) * 32'(b);
    case (op)
      3'd0:    model = {1'b0, a} + {1'b0, b};
      3'd1:    model = {(a < b), a - b};
      3'd2:    model = {1'b0, a & b};
      3'd3:    model = {1'b0, a | b};
      3'd4:    model = {1'b0, a ^ b};
      3'd5:    model = {1'b0, a << sh};
      3'd6:    model = {1'b0, a >> sh};
      default: model = {1'b0, p[15:0]};
    endcase
  endfunction

  task automatic preload(input logic [3:0] addr, input logic [15:0] data);
    pl_we   = 1'b1;
    pl_addr = addr;
    pl_data = data;
    @(posedge clk);
    #1;
    pl_we = 1'b0;
  endtask

  // Waits for in_ready, drives one instruction for a single cycle and returns after the accept edge.
  task automatic send(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                      input logic [3:0] rs2);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op    = 3'($urandom);
    in_rd    = 4'($urandom);
    in_rs1   = 4'($urandom);
    in_rs2   = 4'($urandom);
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2);
    exp_t        e;
    logic [16:0] r;
    r      = model(op, rf[rs1], rf[rs2]);
    e.rd   = rd;
    e.data = r[15:0];
    e.z    = (r[15:0] == 16'h0);
    e.c    = r[16];
    e.lat  = (op == 3'b111) ? 18 : 3;
    sb.push_back(e);
    send(op, rd, rs1, rs2);
  endtask

  // Called just after the accept edge; optionally pokes in_valid while the stage is busy.
  task automatic expect_wb(input bit poke);
    exp_t e;
    int   cnt;
    cnt = 0;
    while (!we && cnt < 40) begin
      if (cnt == 1) check("busy_ready", 32'(in_ready), 32'd0);
      in_valid = poke && cnt[0];
      @(posedge clk);
      #1;
      cnt++;
    end
    in_valid = 1'b0;
    e = sb.pop_front();
    if (!we) begin
      check("wb_timeout", 32'(we), 32'd1);
    end else begin
      check("latency", 32'(cnt + 1), 32'(e.lat));
      check("waddr", 32'(waddr), 32'(e.rd));
      check("wdata", 32'(wdata), 32'(e.data));
      check("done", 32'(done), 32'd1);
      @(posedge clk);
      #1;
      check("flag_z", 32'(flag_z), 32'(e.z));
      check("flag_c", 32'(flag_c), 32'(e.c));
      check("ready_after_wb", 32'(in_ready), 32'd1);
      check("we_after_wb", 32'(we), 32'd0);
      check("rf_commit", 32'(rf[e.rd]), 32'(e.data));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_we"}, 32'(we), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_outs"}, {7'd0, waddr, wdata, raddr1, raddr2, flag_z, flag_c}, 32'd0);
  endtask

  initial begin
    int base;
    int n;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset");

    for (int i = 0; i < 16; i++) preload(4'(i), 16'h0);
    preload(4'd0, 16'h7777);
    preload(4'd2, 16'h1234);
    preload(4'd7, 16'hABCD);
    preload(4'd1, 16'hFFFF);
    preload(4'd4, 16'h0001);
    preload(4'd8, 16'h0012);
    preload(4'd9, 16'h0034);
    preload(4'd10, 16'hF0F0);
    preload(4'd11, 16'h0FF3);
    preload(4'd13, 16'h0003);
    preload(4'd14, 16'h5555);

    issue(3'b000, 4'd3, 4'd2, 4'd7);
    expect_wb(1'b0);
    check("add_const", 32'(rf[3]), 32'h0000_BE01);

    issue(3'b000, 4'd5, 4'd1, 4'd4);
    expect_wb(1'b0);
    check("add_wrap_z", {flag_z, flag_c}, 32'd3);
    issue(3'b001, 4'd6, 4'd4, 4'd1);
    expect_wb(1'b0);
    check("sub_borrow", 32'(rf[6]), 32'h0000_0002);

    issue(3'b111, 4'd15, 4'd8, 4'd9);
    expect_wb(1'b1);
    check("mul_const", 32'(rf[15]), 32'h0000_03A8);

    for (int i = 2; i <= 6; i++) begin
      issue(3'(i), 4'd12, 4'd10, (i == 6) ? 4'd13 : 4'd11);
      expect_wb(1'b0);
    end
    check("shr_const", 32'(rf[12]), 32'h0000_1E1E);

    preload(4'd7, 16'h0004);
    issue(3'b000, 4'd2, 4'd2, 4'd2);
    expect_wb(1'b0);
    check("dep_first", 32'(rf[2]), 32'h0000_2468);
    issue(3'b101, 4'd2, 4'd2, 4'd7);
    expect_wb(1'b0);
    check("dep_second", 32'(rf[2]), 32'h0000_4680);

    // Reset ten cycles into a multiply: nothing may ever be written.
    base = we_cnt;
    send(3'b111, 4'd14, 4'd8, 4'd9);
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("mul_abort");
    repeat (25) @(posedge clk);
    #1;
    check("mul_abort_nowrite", 32'(we_cnt - base), 32'd0);
    check("mul_abort_rf", 32'(rf[14]), 32'h0000_5555);

    // Reset asserted in the WB cycle: the write is suppressed.
    send(3'b000, 4'd14, 4'd2, 4'd7);
    n = 0;
    while (!we && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wb_reached", 32'(we), 32'd1);
    rst = 1'b1;
    #1;
    check("wb_rst_we", 32'(we), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("wb_abort");
    check("wb_abort_nowrite", 32'(we_cnt - base), 32'd0);
    check("wb_abort_rf", 32'(rf[14]), 32'h0000_5555);

    issue(3'b000, 4'd0, 4'd1, 4'd4);
    expect_wb(1'b0);
    check("r0_written", 32'(rf[0]), 32'h0000_0000);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
